// File: rtl/alu593_req_arbiter.sv
// Round-robin arbiter that shares one ALU593 datapath between NREQ requesters.
// Define ALU_ARB_TIMEOUT_EN to abort a WAIT that lasts TIMEOUT_CYC cycles with rsp_err=1.
module alu593_req_arbiter #(
  parameter int NREQ        = 2,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [4*NREQ-1:0]   req_op,
  input  logic [8*NREQ-1:0]   req_a,
  input  logic [8*NREQ-1:0]   req_b,
  output logic [NREQ-1:0]     req_ready,
  output logic [NREQ-1:0]     rsp_valid,
  output logic [15:0]         rsp_result,
  output logic                rsp_err,
  output logic [3:0]          alu_op,
  output logic [7:0]          alu_a,
  output logic [7:0]          alu_b,
  output logic                alu_start,
  input  logic                alu_done,
  input  logic [15:0]         alu_result,
  output logic                busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  if (NREQ < 2 || NREQ > 8 || TIMEOUT_CYC < 1) begin : g_param_check
    $error("alu593_req_arbiter: NREQ must be 2..8 and TIMEOUT_CYC at least 1");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t         state, state_next;
  logic [PW-1:0]  rr_ptr;
  logic [PW-1:0]  grant_idx;
  logic           grant_found;
  logic [3:0]     grant_op;
  logic [7:0]     grant_a, grant_b;
  logic           grant_reserved;
  logic [PW-1:0]  cmd_idx;
  logic [3:0]     cmd_op;
  logic [7:0]     cmd_a, cmd_b;
  logic           wait_timeout;

  // First valid requester at or after rr_ptr, wrapping NREQ-1 -> 0.
  always_comb begin
    int idx;
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    grant_found = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    for (int i = 0; i < NREQ; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!grant_found && req_valid[idx]) begin
        grant_found = 1'b1;
        grant_idx   = PW'(idx);
      end
    end
  end

  assign grant_op       = req_op[4*int'(grant_idx) +: 4];
  assign grant_a        = req_a[8*int'(grant_idx) +: 8];
  assign grant_b        = req_b[8*int'(grant_idx) +: 8];
  assign grant_reserved = (grant_op >= 4'hA) && (grant_op <= 4'hE);

  always_comb begin
    state_next = state;
    req_ready  = '0;
    rsp_valid  = '0;
    alu_start  = 1'b0;
    case (state)
      IDLE: begin
        if (grant_found) begin
          req_ready[grant_idx] = 1'b1;
          state_next = grant_reserved ? RESP : ISSUE;
        end
      end
      ISSUE: begin
        alu_start  = 1'b1;
        state_next = WAIT;
      end
      WAIT: begin
        if (alu_done || wait_timeout) state_next = RESP;
      end
      RESP: begin
        rsp_valid[cmd_idx] = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      cmd_idx    <= '0;
      cmd_op     <= '0;
      cmd_a      <= '0;
      cmd_b      <= '0;
      rsp_result <= '0;
      rsp_err    <= 1'b0;
    end else begin
      state <= state_next;
      if (state == IDLE && grant_found) begin
        cmd_idx <= grant_idx;
        cmd_op  <= grant_op;
        cmd_a   <= grant_a;
        cmd_b   <= grant_b;
        rr_ptr  <= (grant_idx == PW'(NREQ-1)) ? '0 : grant_idx + PW'(1);
        if (grant_reserved) begin
          rsp_result <= '0;
          rsp_err    <= 1'b1;
        end
      end
      // An alu_done during ISSUE is stale: only WAIT looks at it.
      if (state == WAIT) begin
        if (alu_done) begin
          rsp_result <= alu_result;
          rsp_err    <= 1'b0;
        end else if (wait_timeout) begin
          rsp_result <= '0;
          rsp_err    <= 1'b1;
        end
      end
    end
  end

`ifdef ALU_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  logic [CNT_W-1:0] wait_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)            wait_cnt <= '0;
    else if (state == ISSUE) wait_cnt <= '0;
    else if (state == WAIT)  wait_cnt <= wait_cnt + CNT_W'(1);
  end

  assign wait_timeout = (state == WAIT) && !alu_done && (wait_cnt == CNT_W'(TIMEOUT_CYC-1));
`else
  assign wait_timeout = 1'b0;
`endif

  // The command registers hold op/a/b steady from ISSUE through WAIT.
  assign alu_op = cmd_op;
  assign alu_a  = cmd_a;
  assign alu_b  = cmd_b;
  assign busy   = (state != IDLE);

endmodule

// File: tb/tb_alu593_req_arbiter.sv
// Self-checking bench for alu593_req_arbiter: requester drivers, ALU responder and a response scoreboard.
// Build with ALU_ARB_TIMEOUT_EN defined to also exercise the WAIT watchdog.
module tb_alu593_req_arbiter;
  localparam int NREQ = 2;
  localparam int TO   = 8;

  typedef struct packed {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
  } cmd_t;

  typedef struct {
    int          idx;
    logic [15:0] result;
    logic        err;
  } exp_t;

  logic                clk = 1'b0;
  logic                reset_n;
  logic [NREQ-1:0]     req_valid;
  logic [4*NREQ-1:0]   req_op;
  logic [8*NREQ-1:0]   req_a, req_b;
  logic [NREQ-1:0]     req_ready, rsp_valid;
  logic [15:0]         rsp_result;
  logic                rsp_err;
  logic [3:0]          alu_op;
  logic [7:0]          alu_a, alu_b;
  logic                alu_start, alu_done, busy;
  logic [15:0]         alu_result;

  int checks = 0;
  int errors = 0;

  cmd_t pend[NREQ][$];
  exp_t sb[$];
  int   acc_q[$];
  int   cyc = 0;
  int   start_cnt = 0, rsp_cnt = 0;
  int   last_acc_cyc = 0, last_start_cyc = 0, last_rsp_cyc = 0;
  int   alu_lat = 1;
  bit   alu_hang = 1'b0;

  alu593_req_arbiter #(.NREQ(NREQ), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_result(rsp_result), .rsp_err(rsp_err),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_start(alu_start),
    .alu_done(alu_done), .alu_result(alu_result), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] alu_f(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      4'h1:    return {8'h00, a} + {8'h00, b};
      4'h4:    return {8'h00, a} * {8'h00, b};
      default: return {a ^ b, op, ~op};
    endcase
  endfunction

  function automatic bit is_reserved(input logic [3:0] op);
    return (op >= 4'hA) && (op <= 4'hE);
  endfunction

  function automatic bit pend_empty();
    for (int i = 0; i < NREQ; i++) if (pend[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  // Requesters: accept seen at the negedge, next command presented just after the posedge.
  initial begin : driver
    cmd_t c;
    exp_t e;
    req_valid = '0; req_op = '0; req_a = '0; req_b = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NREQ; i++) begin
        if (reset_n && req_valid[i] && req_ready[i] && pend[i].size() != 0) begin
          c = pend[i].pop_front();
          e.idx = i;
          if (is_reserved(c.op))  begin e.result = 16'h0000; e.err = 1'b1; end
          else if (alu_hang)      begin e.result = 16'h0000; e.err = 1'b1; end
          else                    begin e.result = alu_f(c.op, c.a, c.b); e.err = 1'b0; end
          sb.push_back(e);
          acc_q.push_back(i);
          last_acc_cyc = cyc;
        end
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) begin
        if (pend[i].size() != 0) begin
          req_valid[i]       = 1'b1;
          req_op[4*i +: 4]   = pend[i][0].op;
          req_a[8*i +: 8]    = pend[i][0].a;
          req_b[8*i +: 8]    = pend[i][0].b;
        end else begin
          req_valid[i] = 1'b0;
        end
      end
    end
  end

  // ALU responder: answers alu_latency negedges after it sees alu_start, checking op/a/b hold.
  initial begin : alu_model
    cmd_t cap;
    bit   aborted;
    alu_done = 1'b0; alu_result = '0;
    forever begin
      @(negedge clk);
      if (reset_n && alu_start) begin
        start_cnt++;
        last_start_cyc = cyc;
        cap = {alu_op, alu_a, alu_b};
        aborted = 1'b0;
        for (int k = 0; k < alu_lat && !aborted; k++) begin
          @(negedge clk);
          if (!reset_n) aborted = 1'b1;
          else begin
            checks++;
            if (alu_start !== 1'b0 || {alu_op, alu_a, alu_b} !== cap) begin
              errors++;
              $display("FAIL wait_hold: start=%b op/a/b=%h required start=0 op/a/b=%h",
                       alu_start, {alu_op, alu_a, alu_b}, cap);
            end
          end
        end
        if (!aborted && !alu_hang) begin
          alu_done   = 1'b1;
          alu_result = alu_f(cap.op, cap.a, cap.b);
          @(negedge clk);
          alu_done   = 1'b0;
        end
      end
    end
  end

  initial begin : rsp_monitor
    exp_t e;
    logic [NREQ-1:0] ev;
    forever begin
      @(negedge clk);
      if (rsp_valid !== '0) begin
        rsp_cnt++;
        last_rsp_cyc = cyc;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL rsp_unexpected: rsp_valid=%b required no response", rsp_valid);
        end else begin
          e = sb.pop_front();
          ev = '0;
          ev[e.idx] = 1'b1;
          if (rsp_valid !== ev || rsp_result !== e.result || rsp_err !== e.err) begin
            errors++;
            $display("FAIL rsp_data: valid=%b result=%h err=%b required valid=%b result=%h err=%b",
                     rsp_valid, rsp_result, rsp_err, ev, e.result, e.err);
          end
        end
      end
    end
  end

  task automatic drain(input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (sb.size() == 0 && pend_empty() && busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({req_ready, rsp_valid, rsp_result, rsp_err, alu_op, alu_a, alu_b, alu_start, busy} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b start=%b rsp_valid=%b result=%h required all zero",
               busy, alu_start, rsp_valid, rsp_result);
    end
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, alu_start, rsp_valid, req_ready} !== '0) begin
      errors++;
      $display("FAIL reset_release: busy=%b start=%b required idle", busy, alu_start);
    end
  endtask

  task automatic test_single();
    bit ok;
    int s0 = start_cnt;
    acc_q.delete();
    pend[0].push_back({4'h1, 8'h12, 8'h34});
    drain(50, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL single_timeout: got no completion required completion"); end
    checks++;
    if (start_cnt - s0 != 1) begin
      errors++; $display("FAIL single_starts: got %0d required 1", start_cnt - s0);
    end
    checks++;
    if (last_start_cyc != last_acc_cyc + 1) begin
      errors++; $display("FAIL single_start_lat: got %0d required %0d", last_start_cyc - last_acc_cyc, 1);
    end
    checks++;
    if (last_rsp_cyc != last_acc_cyc + 3) begin
      errors++; $display("FAIL single_rsp_lat: got %0d required %0d", last_rsp_cyc - last_acc_cyc, 3);
    end
    checks++;
    if (rsp_result !== 16'h0046 || rsp_err !== 1'b0) begin
      errors++; $display("FAIL single_result: got %h/%b required 0046/0", rsp_result, rsp_err);
    end
  endtask

  task automatic test_reserved();
    bit ok;
    int s0 = start_cnt;
    acc_q.delete();
    pend[1].push_back({4'hC, 8'h55, 8'hAA});
    drain(50, ok);
    checks++;
    if (!ok || acc_q.size() != 1 || acc_q[0] != 1) begin
      errors++; $display("FAIL reserved_grant: got %0d grants required one to requester 1", acc_q.size());
    end
    checks++;
    if (start_cnt != s0) begin
      errors++; $display("FAIL reserved_start: got %0d starts required 0", start_cnt - s0);
    end
    checks++;
    if (last_rsp_cyc != last_acc_cyc + 1) begin
      errors++; $display("FAIL reserved_lat: got %0d required 1", last_rsp_cyc - last_acc_cyc);
    end
    checks++;
    if (rsp_result !== 16'h0000 || rsp_err !== 1'b1) begin
      errors++; $display("FAIL reserved_result: got %h/%b required 0000/1", rsp_result, rsp_err);
    end
  endtask

  task automatic test_round_robin();
    bit ok;
    acc_q.delete();
    alu_lat = 1;
    for (int k = 0; k < 4; k++) begin
      pend[0].push_back({4'(3*k), 8'(17*k + 1), 8'(8'hF0 - k)});
      pend[1].push_back({4'(15 - 5*k), 8'(8'h80 + k), 8'(29*k)});
    end
    drain(300, ok);
    checks++;
    if (!ok || acc_q.size() != 8) begin
      errors++; $display("FAIL rr_count: got %0d grants required 8", acc_q.size());
    end
    for (int k = 0; k < acc_q.size(); k++) begin
      checks++;
      if (acc_q[k] != k % 2) begin
        errors++; $display("FAIL rr_order[%0d]: got %0d required %0d", k, acc_q[k], k % 2);
      end
    end
  endtask

  task automatic test_long_wait();
    bit ok;
    alu_lat = 10;
    pend[0].push_back({4'h4, 8'hFF, 8'hFF});
    drain(80, ok);
    checks++;
    if (!ok || rsp_result !== 16'hFE01 || rsp_err !== 1'b0) begin
      errors++; $display("FAIL long_result: got %h/%b required FE01/0", rsp_result, rsp_err);
    end
    checks++;
    if (last_rsp_cyc != last_acc_cyc + 12) begin
      errors++; $display("FAIL long_lat: got %0d required 12", last_rsp_cyc - last_acc_cyc);
    end
    alu_lat = 1;
  endtask

  task automatic test_reset_mid_wait();
    bit ok;
    int r0;
    alu_lat = 20;
    pend[0].push_back({4'h1, 8'h01, 8'h02});
    repeat (6) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL midwait_busy: got %b required 1", busy); end
    #2;
    reset_n = 1'b0;
    sb.delete();
    #1;
    checks++;
    if ({busy, alu_start, rsp_valid} !== '0) begin
      errors++; $display("FAIL midwait_reset: busy=%b start=%b rsp_valid=%b required all zero",
                         busy, alu_start, rsp_valid);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    r0 = rsp_cnt;
    repeat (30) @(negedge clk);
    checks++;
    if (rsp_cnt != r0) begin errors++; $display("FAIL midwait_norsp: got %0d responses required 0", rsp_cnt - r0); end
    alu_lat = 1;
    acc_q.delete();
    pend[0].push_back({4'h1, 8'h21, 8'h43});
    pend[1].push_back({4'h4, 8'h03, 8'h05});
    drain(60, ok);
    checks++;
    if (!ok || acc_q.size() != 2 || acc_q[0] != 0 || acc_q[1] != 1) begin
      errors++; $display("FAIL midwait_rrptr: got %0d grants first=%0d required 2 grants first=0",
                         acc_q.size(), (acc_q.size() != 0) ? acc_q[0] : -1);
    end
  endtask

`ifdef ALU_ARB_TIMEOUT_EN
  task automatic test_timeout();
    bit ok;
    alu_hang = 1'b1;
    alu_lat  = TO;
    pend[1].push_back({4'h1, 8'h03, 8'h04});
    drain(60, ok);
    checks++;
    if (!ok || rsp_result !== 16'h0000 || rsp_err !== 1'b1) begin
      errors++; $display("FAIL timeout_result: got %h/%b required 0000/1", rsp_result, rsp_err);
    end
    checks++;
    if (last_rsp_cyc != last_acc_cyc + TO + 2) begin
      errors++; $display("FAIL timeout_lat: got %0d required %0d", last_rsp_cyc - last_acc_cyc, TO + 2);
    end
    alu_hang = 1'b0;
    alu_lat  = 1;
    pend[0].push_back({4'h1, 8'h05, 8'h06});
    drain(60, ok);
    checks++;
    if (!ok || rsp_result !== 16'h000B || rsp_err !== 1'b0) begin
      errors++; $display("FAIL timeout_next: got %h/%b required 000B/0", rsp_result, rsp_err);
    end
  endtask
`endif

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : main
    test_reset();
    test_single();
    test_reserved();
    test_round_robin();
    test_long_wait();
    test_reset_mid_wait();
`ifdef ALU_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
